// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and defaults for the register-file write arbiter.
// Holds the FSM state enumeration, the requester-ID encoding and the default widths.
// Imported by regfile_write_arbiter and rr_arbiter2.
package regfile_write_arbiter_pkg;

  localparam int DEF_DW = 8;
  localparam int DEF_AW = 3;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-requester round-robin grant: on contention the requester that did not win last gets the grant.
// Latency: purely combinational.
// Backpressure: en=0 withholds both grants; at most one grant is high.
// Ports: en (grant allowed), a_valid/b_valid (requests), last_grant (previous winner),
//        grant_a/grant_b (one-hot or zero grant outputs).
module rr_arbiter2
  import regfile_write_arbiter_pkg::*;
(
  input  logic    en,
  input  logic    a_valid,
  input  logic    b_valid,
  input  req_id_t last_grant,
  output logic    grant_a,
  output logic    grant_b
);

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (en) begin
      if (a_valid && b_valid) begin
        // Contention: hand the grant to whoever did not win last time.
        if (last_grant == REQ_A) begin
          grant_b = 1'b1;
        end else begin
          grant_a = 1'b1;
        end
      end else begin
        grant_a = a_valid;
        grant_b = b_valid;
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates two write requesters onto one register-file write port, plus a zero-fill sweep.
// Latency: a transfer in cycle T appears on rf_* in T+1; a clear started at T writes addr k at T+2+k.
// Backpressure: a_ready/b_ready drop during reset, during a sweep, and in the cycle clr_start is seen.
// Ports: clk/rst (sync active-high); a_*/b_* valid-ready requesters; clr_start/clr_busy/clr_done
//        sweep control and status; rf_we/rf_waddr/rf_wdata registered external write port.
module regfile_write_arbiter #(
  parameter int DW = regfile_write_arbiter_pkg::DEF_DW,
  parameter int AW = regfile_write_arbiter_pkg::DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  input  logic          clr_start,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata
);
  import regfile_write_arbiter_pkg::*;

  localparam logic [AW-1:0] CNT_MAX = {AW{1'b1}};

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  req_id_t       last_grant_q;

  logic          arb_en;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_last;

  // A clr_start in ARB wins over both requesters in the same cycle.
  assign arb_en = (state_q == ARB) && !clr_start && !rst;

  rr_arbiter2 u_rr (
    .en         (arb_en),
    .a_valid    (a_valid),
    .b_valid    (b_valid),
    .last_grant (last_grant_q),
    .grant_a    (a_ready),
    .grant_b    (b_ready)
  );

  assign clr_busy = (state_q == CLEAR);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    wr_last = 1'b0;
    case (state_q)
      ARB: begin
        if (clr_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else if (a_ready) begin
          wr_en   = 1'b1;
          wr_addr = a_addr;
          wr_data = a_data;
        end else if (b_ready) begin
          wr_en   = 1'b1;
          wr_addr = b_addr;
          wr_data = b_data;
        end
      end
      CLEAR: begin
        // clr_start is deliberately not looked at here: no restart, no queuing.
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_data = '0;
        if (cnt_q == CNT_MAX) begin
          // Counter parks at its top value; the next sweep reloads it from ARB.
          wr_last = 1'b1;
          state_d = ARB;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB;
      cnt_q        <= '0;
      last_grant_q <= REQ_B;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      clr_done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rf_we    <= wr_en;
      clr_done <= wr_last;
      // Address/data hold their last value when no write is presented.
      if (wr_en) begin
        rf_waddr <= wr_addr;
        rf_wdata <= wr_data;
      end
      if (a_ready) begin
        last_grant_q <= REQ_A;
      end else if (b_ready) begin
        last_grant_q <= REQ_B;
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against a behavioural model.
// Inputs change on the falling edge; all outputs are compared 1 ns later.
// Model tracks expected readys, write port, sweep progress and an 8-entry register image.
module tb_regfile_write_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_valid = 1'b0, b_valid = 1'b0, clr_start = 1'b0;
  logic [2:0] a_addr = '0, b_addr = '0;
  logic [7:0] a_data = '0, b_data = '0;
  logic       a_ready, b_ready, clr_busy, clr_done, rf_we;
  logic [2:0] rf_waddr;
  logic [7:0] rf_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: clr_left = number of clear writes still to be issued (0 = arbitrating).
  int         clr_left  = 0;
  int         clr_next  = 0;
  int         last_win  = 1;      // 0 = A, 1 = B
  logic       m_we      = 1'b0;
  logic [2:0] m_waddr   = '0;
  logic [7:0] m_wdata   = '0;
  logic       m_done    = 1'b0;
  logic [7:0] mdl_mem [8];
  logic [7:0] dut_mem [8];
  int         done_seen = 0;
  int         clr_writes = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.DW(8), .AW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .a_valid   (a_valid),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, check outputs against the model, then advance the model.
  task automatic cycle(input logic r, input logic av, input logic [2:0] aa, input logic [7:0] ad,
                       input logic bv, input logic [2:0] ba, input logic [7:0] bd, input logic cs);
    logic ea, eb;
    @(negedge clk);
    rst = r; a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd; clr_start = cs;
    #1;
    ea = 1'b0; eb = 1'b0;
    if (!r && clr_left == 0 && !cs) begin
      if (av && (!bv || last_win == 1)) ea = 1'b1;
      else if (bv) eb = 1'b1;
    end
    chk("a_ready", a_ready, ea);
    chk("b_ready", b_ready, eb);
    chk("rf_we", rf_we, m_we);
    chk("rf_waddr", rf_waddr, m_waddr);
    chk("rf_wdata", rf_wdata, m_wdata);
    chk("clr_done", clr_done, m_done);
    chk("clr_busy", clr_busy, clr_left != 0);
    if (rf_we === 1'b1) dut_mem[rf_waddr] = rf_wdata;
    if (clr_done === 1'b1) done_seen++;
    if (rf_we === 1'b1 && clr_busy === 1'b0 && clr_done === 1'b0 && rf_wdata === 8'h00) begin
      // not a clear write by itself; clear writes are counted via the model below
    end
    // Advance the model across the coming rising edge.
    if (r) begin
      clr_left = 0; last_win = 1;
      m_we = 1'b0; m_waddr = '0; m_wdata = '0; m_done = 1'b0;
    end else if (clr_left != 0) begin
      m_we = 1'b1; m_waddr = clr_next[2:0]; m_wdata = 8'h00;
      m_done = (clr_left == 1);
      mdl_mem[clr_next] = 8'h00;
      clr_writes++;
      clr_next++;
      clr_left--;
    end else if (cs) begin
      clr_left = 8; clr_next = 0; m_we = 1'b0; m_done = 1'b0;
    end else if (ea || eb) begin
      m_we = 1'b1; m_done = 1'b0;
      m_waddr = ea ? aa : ba;
      m_wdata = ea ? ad : bd;
      mdl_mem[m_waddr] = m_wdata;
      last_win = ea ? 0 : 1;
    end else begin
      m_we = 1'b0; m_done = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      mdl_mem[i] = 8'h00;
      dut_mem[i] = 8'h00;
    end

    // Reset state, including readys held low while rst is high.
    cycle(1'b1, 1'b1, 3'd1, 8'h01, 1'b1, 3'd2, 8'h02, 1'b0);
    cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0);

    // A-only write to address 3.
    cycle(1'b0, 1'b1, 3'd3, 8'h5A, 1'b0, 3'd0, 8'h00, 1'b0);
    chk("a_only_ready", a_ready, 1'b1);
    idle(1);
    chk("a_only_we", rf_we, 1'b1);
    chk("a_only_addr", rf_waddr, 3'd3);
    chk("a_only_data", rf_wdata, 8'h5A);

    // Contention right after reset: A first, then B.
    cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 1'b0);
    chk("cont_first_a", a_ready, 1'b1);
    cycle(1'b0, 1'b1, 3'd1, 8'h11, 1'b1, 3'd2, 8'h22, 1'b0);
    chk("cont_second_b", b_ready, 1'b1);
    chk("cont_wr_a", rf_wdata, 8'h11);
    idle(1);
    chk("cont_wr_b", rf_wdata, 8'h22);

    // Same address with last_grant=A: B lands first, A's value is final.
    cycle(1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 3'd4, 8'hAA, 1'b1, 3'd4, 8'hBB, 1'b0);
    chk("same_b_first", b_ready, 1'b1);
    cycle(1'b0, 1'b1, 3'd4, 8'hAA, 1'b0, 3'd4, 8'hBB, 1'b0);
    chk("same_wr_b", rf_wdata, 8'hBB);
    idle(1);
    chk("same_wr_a", rf_wdata, 8'hAA);
    chk("same_reg4", dut_mem[4], 8'hAA);

    // Clear sweep with A waiting, plus an ignored second clr_start at T+4.
    done_seen = 0; clr_writes = 0;
    cycle(1'b0, 1'b1, 3'd6, 8'h66, 1'b0, 3'd0, 8'h00, 1'b1);
    for (int k = 1; k <= 8; k++)
      cycle(1'b0, 1'b1, 3'd6, 8'h66, 1'b0, 3'd0, 8'h00, k == 4);
    cycle(1'b0, 1'b1, 3'd6, 8'h66, 1'b0, 3'd0, 8'h00, 1'b0);
    chk("clr_last_addr", rf_waddr, 3'd7);
    chk("clr_done_pulse", clr_done, 1'b1);
    chk("clr_a_accept", a_ready, 1'b1);
    idle(2);
    chk("clr_write_cnt", clr_writes, 8);
    chk("clr_done_cnt", done_seen, 1);
    for (int i = 0; i < 8; i++) chk("clr_reg", dut_mem[i], (i == 6) ? 8'h66 : 8'h00);

    // Reset at T+5 aborts the sweep: no more writes, no done pulse.
    done_seen = 0;
    cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b1);
    idle(4);
    cycle(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0);
    idle(10);
    chk("abort_done_cnt", done_seen, 0);
    cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd5, 8'h55, 1'b0);
    chk("abort_b_ready", b_ready, 1'b1);

    // Randomized traffic with occasional clears and resets.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 79) == 0),
            1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom),
            1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom),
            ($urandom_range(0, 24) == 0));
    end
    idle(10);
    for (int i = 0; i < 8; i++) chk("rand_reg", dut_mem[i], mdl_mem[i]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 SHALL have parameter DW, default 8, meaning data width of the write port.
REQ-002 SHALL have parameter AW, default 3, meaning address width (2**AW registers).
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning synchronous, active-high reset.
REQ-005 SHALL have ports a_valid input 1, a_addr input AW, a_data input DW  meaning requester A write request.
REQ-006 SHALL have port a_ready  output  1  meaning requester A request accepted this cycle.
REQ-007 SHALL have ports b_valid input 1, b_addr input AW, b_data input DW  meaning requester B write request.
REQ-008 SHALL have port b_ready  output  1  meaning requester B request accepted this cycle.
REQ-009 SHALL have port clr_start  input  1  meaning a single-cycle pulse that requests a zero-fill of all registers.
REQ-010 SHALL have port clr_busy  output  1  meaning a clear sweep is in progress.
REQ-011 SHALL have port clr_done  output  1  meaning a one-cycle pulse when the last clear write is presented.
REQ-012 SHALL have ports rf_we output 1, rf_waddr output AW, rf_wdata output DW  meaning the register-file write port, all registered.

Function
REQ-013 SHALL implement FSM states ARB and CLEAR.
REQ-014 In ARB, a transfer SHALL occur on a port when valid and ready are both high in the same cycle.
REQ-015 a_ready and b_ready SHALL be combinational from valid inputs, FSM state, clr_start and last_grant; at most one SHALL be high per cycle.
REQ-016 When only one requester is valid in ARB and clr_start is low, that requester SHALL be granted.
REQ-017 When both requesters are valid, the one not equal to last_grant SHALL be granted, giving round-robin order.
REQ-018 last_grant SHALL update only on a transfer.
REQ-019 A transfer in cycle T SHALL produce rf_we=1 with rf_waddr and rf_wdata equal to the granted requester's values in cycle T+1.
REQ-020 In any cycle without a transfer or clear write, rf_we SHALL be 0, and rf_waddr and rf_wdata SHALL hold their previous values.
REQ-021 A loser with the same address as the winner SHALL be served on a later cycle, so the later grant's data is the final register value.
REQ-022 If clr_start is high in ARB in cycle T, both readys SHALL be 0 in cycle T, and the FSM SHALL be in CLEAR with counter 0 at T+1.
REQ-023 In CLEAR with counter k, the block SHALL present rf_we=1, rf_waddr=k, rf_wdata=0 in the next cycle, and the counter SHALL increment.
REQ-024 clr_busy SHALL be high exactly for the 2**AW CLEAR cycles (T+1..T+8 at default).
REQ-025 While in CLEAR, both readys SHALL be 0.
REQ-026 The write to address 2**AW-1 SHALL appear at T+9, with clr_done=1 only in that cycle.
REQ-027 The FSM SHALL be back in ARB at T+9, so a transfer at T+9 writes at T+10.
REQ-028 clr_start asserted while in CLEAR SHALL be ignored, with no restart and no queuing.
REQ-029 The clear counter SHALL be AW bits wide and SHALL stop at 2**AW-1 without wrapping into a second sweep.

Reset
REQ-030 rst SHALL force state ARB, clear counter 0, last_grant=B (so A wins the first contention), rf_we=0, rf_waddr=0, rf_wdata=0, clr_busy=0 and clr_done=0 on the next edge.
REQ-031 rst asserted mid-CLEAR SHALL abort the sweep: no further clear writes and no clr_done pulse.
REQ-032 During rst, a_ready and b_ready SHALL be 0.

Structure
REQ-033 A shared package SHALL hold the FSM state enumeration (ARB, CLEAR), the requester-ID encoding (REQ_A=0, REQ_B=1), and default DW/AW constants.
REQ-034 The two-requester round-robin grant logic (valid inputs, last_grant, grant outputs) SHALL be a sub-module named rr_arbiter2.
REQ-035 The block SHALL contain no register-file storage; it drives an external write port only.

Verification
REQ-036 A only: a_valid=1, a_addr=3, a_data=0x5A for one cycle -> a_ready=1 that cycle; next cycle rf_we=1, rf_waddr=3, rf_wdata=0x5A.
REQ-037 Contention after reset: A(addr 1, 0x11) and B(addr 2, 0x22) both held valid -> A granted at T, B at T+1; writes appear at T+1 and T+2.
REQ-038 Same-address contention: A(addr 4, 0xAA) and B(addr 4, 0xBB) held valid with last_grant=A -> B writes 0xBB first, then A writes 0xAA, and a modelled register 4 ends at 0xAA.
REQ-039 Clear sweep: clr_start pulse at T with a_valid=1 -> a_ready=0 T..T+8; rf writes of zero to addresses 0..7 at T+2..T+9; clr_done only at T+9; A accepted at T+9.
REQ-040 Second clr_start at T+4 -> ignored; exactly 8 clear writes and one clr_done pulse.
REQ-041 rst at T+5 during a sweep -> rf_we=0 from T+6, clr_busy=0, no clr_done, and readys follow REQ-016 after rst is released.
